alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_mul_seq.sv | 43 ++++
 rtl/alu_pipe.sv | 83 ++++++++
 tb/tb_alu_pipe.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and the single-cycle ALU function shared by alu_pipe
package alu_pkg;
    localparam int MAX_W = 32;
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_SLT = 4'b0011,
        OP_AND = 4'b1000, OP_OR = 4'b1001, OP_XOR = 4'b1010, OP_NOT = 4'b1011,
        OP_SRL = 4'b1100, OP_SLL = 4'b1101, OP_ROR = 4'b1110, OP_ROL = 4'b1111;
    typedef enum logic {ST_IDLE, ST_MUL} state_t;
    typedef struct packed {
        logic [MAX_W-1:0] res;
        logic             carry;
        logic             ovf;
        logic             ill;
    } alu_res_t;

    function automatic logic bit_at(input logic [MAX_W:0] x, input int n);
        logic [MAX_W:0] t;
        t = x >> n;
        return t[0];
    endfunction

    // Operands arrive zero-extended to MAX_W; w is the live datapath width.
    function automatic alu_res_t alu_op(input int w, input logic [3:0] op,
                                        input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
        logic [MAX_W-1:0] mask;
        logic [MAX_W:0]   sum, dif;
        logic             sa, sb, rs;
        alu_res_t         r;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        sa = bit_at({1'b0, a}, w - 1);
        sb = bit_at({1'b0, b}, w - 1);
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} - {1'b0, b};
        r = '0;
        case (op)
            OP_ADD: begin r.res = sum[MAX_W-1:0]; r.carry = bit_at(sum, w); end
            OP_SUB: begin r.res = dif[MAX_W-1:0]; r.carry = a < b; end
            OP_MUL: r.ill = 1'b0;
            OP_SLT: r.res = MAX_W'((sa != sb) ? sa : (a < b));
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_XOR: r.res = a ^ b;
            OP_NOT: r.res = ~a;
            OP_SRL: begin r.res = a >> 1; r.carry = a[0]; end
            OP_SLL: begin r.res = a << 1; r.carry = sa; end
            OP_ROR: begin r.res = (a >> 1) | (MAX_W'(a[0]) << (w - 1)); r.carry = a[0]; end
            OP_ROL: begin r.res = (a << 1) | MAX_W'(sa); r.carry = sa; end
            default: r.ill = 1'b1;
        endcase
        r.res = r.res & mask;
        rs = bit_at({1'b0, r.res}, w - 1);
        r.ovf = (op == OP_ADD && sa == sb && rs != sa) || (op == OP_SUB && sa != sb && rs != sa);
        return r;
    endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-step shift-add multiplier producing a 2*WIDTH-bit product
module alu_mul_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    logic               run;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    assign done = run && cnt == CNT_W'(WIDTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            run <= 1'b0;
            cnt <= '0;
            mcand <= '0;
            mplier <= '0;
            product <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            mcand <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            product <= '0;
        end else if (done) begin
            run <= 1'b0;
        end else if (run) begin
            product <= mplier[0] ? product + mcand : product;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with status flags and an iterative shift-add multiply
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_negative,
    output logic             flag_overflow,
    output logic             illegal
);
    state_t             state, state_n;
    alu_res_t           r;
    logic               accept, is_mul, load, mul_done, unused_res;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   res;
    logic               carry, ovf, ill;

    assign in_ready = state == ST_IDLE && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    assign is_mul = control == OP_MUL;
    assign load = (accept && !is_mul) || (state == ST_MUL && mul_done);
    assign r = alu_op(WIDTH, control, MAX_W'(A), MAX_W'(B));
    assign unused_res = ^r.res;

    alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clock(clock),
        .reset(reset),
        .start(accept && is_mul),
        .a(A),
        .b(B),
        .done(mul_done),
        .product(product)
    );

    // While multiplying, control may already carry the next opcode, so the flags come from the product.
    always_comb begin
        state_n = (state == ST_IDLE) ? ((accept && is_mul) ? ST_MUL : ST_IDLE)
                                     : (mul_done ? ST_IDLE : ST_MUL);
        res = (state == ST_MUL) ? product[WIDTH-1:0] : r.res[WIDTH-1:0];
        carry = (state == ST_MUL) ? |product[2*WIDTH-1:WIDTH] : r.carry;
        ovf = (state == ST_MUL) ? 1'b0 : r.ovf;
        ill = (state == ST_MUL) ? 1'b0 : r.ill;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            out_valid <= 1'b0;
            out <= '0;
            flag_zero <= 1'b0;
            flag_carry <= 1'b0;
            flag_negative <= 1'b0;
            flag_overflow <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                out_valid <= 1'b1;
                out <= res;
                flag_zero <= res == '0;
                flag_carry <= carry;
                flag_negative <= res[WIDTH-1];
                flag_overflow <= ovf;
                illegal <= ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe at WIDTH=8
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  A = '0, B = '0;
    logic [3:0]  control = '0;
    logic        in_ready, out_valid, flag_zero, flag_carry, flag_negative, flag_overflow, illegal;
    logic [7:0]  out;
    logic [12:0] got;
    logic [12:0] q[$];
    int          checks = 0, errors = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .control(control),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .flag_zero(flag_zero),
        .flag_carry(flag_carry),
        .flag_negative(flag_negative),
        .flag_overflow(flag_overflow),
        .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign got = {out, flag_zero, flag_carry, flag_negative, flag_overflow, illegal};

    function automatic logic [12:0] f(input logic [7:0] o, input logic z, input logic c,
                                      input logic n, input logic v, input logic i);
        return {o, z, c, n, v, i};
    endfunction

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [12:0] exp, input bit push);
        int n;
        n = 0;
        control = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("accept_timeout", (n < 50), 1);
        if (push) q.push_back(exp);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Every result handed to the consumer is matched against the oldest expectation.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_output: got %h expected none", got);
            end
            if (q.size() > 0) check("result", got, q.pop_front());
        end
    end

    initial begin
        int  n;
        logic seen;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", {got, out_valid, in_ready}, {13'h0, 2'b01});
        reset = 1'b0;

        issue(OP_ADD, 8'h7F, 8'h01, f(8'h80, 0, 0, 1, 1, 0), 1);
        issue(OP_SUB, 8'h00, 8'h01, f(8'hFF, 0, 1, 1, 0, 0), 1);
        issue(OP_SUB, 8'h05, 8'h05, f(8'h00, 1, 0, 0, 0, 0), 1);
        issue(OP_ADD, 8'hFF, 8'h01, f(8'h00, 1, 1, 0, 0, 0), 1);
        issue(OP_SUB, 8'h80, 8'h01, f(8'h7F, 0, 0, 0, 1, 0), 1);
        issue(OP_SLT, 8'hFF, 8'h01, f(8'h01, 0, 0, 0, 0, 0), 1);
        issue(OP_SLT, 8'h01, 8'hFF, f(8'h00, 1, 0, 0, 0, 0), 1);
        issue(OP_AND, 8'hF0, 8'h3C, f(8'h30, 0, 0, 0, 0, 0), 1);
        issue(OP_OR,  8'hF0, 8'h0F, f(8'hFF, 0, 0, 1, 0, 0), 1);
        issue(OP_NOT, 8'h0F, 8'h00, f(8'hF0, 0, 0, 1, 0, 0), 1);
        issue(OP_SRL, 8'h03, 8'h00, f(8'h01, 0, 1, 0, 0, 0), 1);
        issue(OP_SLL, 8'h81, 8'h00, f(8'h02, 0, 1, 0, 0, 0), 1);

        issue(OP_MUL, 8'h10, 8'h11, f(8'h10, 0, 1, 0, 0, 0), 1);
        control = OP_ADD;
        A = 8'hAA;
        for (int i = 0; i < 9; i++) begin
            check("mul_busy", {in_ready, out_valid}, 2'b00);
            @(posedge clock); #1;
        end
        check("mul_done", out_valid, 1);
        issue(OP_MUL, 8'h0F, 8'h0F, f(8'hE1, 0, 0, 1, 0, 0), 1);

        issue(OP_ROR, 8'h01, 8'h00, f(8'h80, 0, 1, 1, 0, 0), 1);
        issue(OP_ROL, 8'h80, 8'h00, f(8'h01, 0, 1, 0, 0, 0), 1);
        issue(4'b0101, 8'h12, 8'h34, f(8'h00, 1, 0, 0, 0, 1), 1);
        @(posedge clock); #1;

        out_ready = 1'b0;
        issue(OP_ADD, 8'h01, 8'h02, f(8'h03, 0, 0, 0, 0, 0), 1);
        control = OP_XOR;
        A = 8'hF0;
        B = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", {out_valid, got}, {1'b1, f(8'h03, 0, 0, 0, 0, 0)});
            @(posedge clock); #1;
        end
        q.push_back(f(8'h0F, 0, 0, 0, 0, 0));
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("bp_xor_loaded", {out_valid, out}, {1'b1, 8'h0F});

        issue(OP_MUL, 8'h03, 8'h04, '0, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_state", {in_ready, out_valid}, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen |= out_valid;
            @(posedge clock); #1;
        end
        check("abort_no_output", seen, 0);
        issue(OP_ADD, 8'h02, 8'h03, f(8'h05, 0, 0, 0, 0, 0), 1);

        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
